// File: rtl/gpio_edge_pkg.sv
// Shared types and constants for the GPIO edge responder.
//   edge_mode_e        per-line edge selection (OFF / RISE / FALL / BOTH)
//   DefaultSyncStages  default synchroniser depth for async inputs
package gpio_edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_e;

  localparam int unsigned DefaultSyncStages = 2;

endpackage : gpio_edge_pkg

// File: rtl/gpio_edge_channel.sv
// One monitored GPIO line: input/ack synchronisers, edge detect, sticky
// irq/overrun flags and a saturating edge counter.
//   clk, rst    clock, async active-high reset
//   gpio_in     raw line (async)
//   ack         raw acknowledge (async); its synced rising edge clears flags
//   edge_mode   which edges raise an event
//   count_clr   synchronous counter clear (wins over a same-cycle edge)
//   irq         sticky event-pending flag
//   overrun     sticky: event arrived while irq already pending
//   gpio_sync   synchronised copy of gpio_in
//   edge_count  saturating count of qualified edges
module gpio_edge_channel
  import gpio_edge_pkg::*;
#(
  parameter int unsigned SyncStages = DefaultSyncStages,
  parameter int unsigned CountWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gpio_in,
  input  logic                  ack,
  input  edge_mode_e            edge_mode,
  input  logic                  count_clr,
  output logic                  irq,
  output logic                  overrun,
  output logic                  gpio_sync,
  output logic [CountWidth-1:0] edge_count
);

  localparam logic [CountWidth-1:0] CountMax = '1;

  logic [SyncStages-1:0] gpio_sh;
  logic [SyncStages-1:0] ack_sh;
  logic                  gpio_prev;
  logic                  ack_prev;
  logic                  gpio_s;
  logic                  ack_s;

  logic                  edge_hit;
  logic                  ack_clear;
  logic                  irq_d;
  logic                  overrun_d;
  logic [CountWidth-1:0] count_d;

  assign gpio_s    = gpio_sh[SyncStages-1];
  assign ack_s     = ack_sh[SyncStages-1];
  assign gpio_sync = gpio_s;

  // Synchroniser chains plus one history flop each for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_sh   <= '0;
      ack_sh    <= '0;
      gpio_prev <= 1'b0;
      ack_prev  <= 1'b0;
    end else begin
      gpio_sh   <= {gpio_sh[SyncStages-2:0], gpio_in};
      ack_sh    <= {ack_sh[SyncStages-2:0], ack};
      gpio_prev <= gpio_s;
      ack_prev  <= ack_s;
    end
  end

  // Mode-qualified edge and ack rising edge (held ack clears only once).
  always_comb begin
    edge_hit  = 1'b0;
    ack_clear = ack_s & ~ack_prev;
    case (edge_mode)
      EDGE_RISE: edge_hit = gpio_s & ~gpio_prev;
      EDGE_FALL: edge_hit = ~gpio_s & gpio_prev;
      EDGE_BOTH: edge_hit = gpio_s ^ gpio_prev;
      default:   edge_hit = 1'b0;
    endcase
  end

  // Flag/counter next state: a new event beats a same-cycle ack for irq,
  // while the ack still clears overrun; count_clr beats an increment.
  always_comb begin
    irq_d     = irq;
    overrun_d = overrun;
    count_d   = edge_count;
    if (edge_hit) begin
      irq_d = 1'b1;
    end else if (ack_clear) begin
      irq_d = 1'b0;
    end
    if (ack_clear) begin
      overrun_d = 1'b0;
    end else if (edge_hit && irq) begin
      overrun_d = 1'b1;
    end
    if (count_clr) begin
      count_d = '0;
    end else if (edge_hit && (edge_count != CountMax)) begin
      count_d = edge_count + CountWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq        <= 1'b0;
      overrun    <= 1'b0;
      edge_count <= '0;
    end else begin
      irq        <= irq_d;
      overrun    <= overrun_d;
      edge_count <= count_d;
    end
  end

endmodule : gpio_edge_channel

// File: rtl/gpio_edge_responder.sv
// Per-line GPIO edge detector / interrupt responder between the Renode GPIO
// outputs (gpio_in, ack) and Renode inputs (irq, overrun).
//   clk, rst    clock, async active-high reset
//   gpio_in     [Width]             monitored lines
//   ack         [Width]             per-line acknowledge
//   edge_mode   [2*Width]           line i mode at [2*i +: 2]
//   count_clr                       clear all edge counters
//   irq         [Width]             sticky event-pending flags
//   overrun     [Width]             sticky overrun flags
//   gpio_sync   [Width]             synchronised gpio_in
//   edge_count  [Width*CountWidth]  line i at [i*CountWidth +: CountWidth]
module gpio_edge_responder
  import gpio_edge_pkg::*;
#(
  parameter int unsigned Width      = 2,
  parameter int unsigned SyncStages = DefaultSyncStages,
  parameter int unsigned CountWidth = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [Width-1:0]            gpio_in,
  input  logic [Width-1:0]            ack,
  input  logic [2*Width-1:0]          edge_mode,
  input  logic                        count_clr,
  output logic [Width-1:0]            irq,
  output logic [Width-1:0]            overrun,
  output logic [Width-1:0]            gpio_sync,
  output logic [Width*CountWidth-1:0] edge_count
);

  // Lines are independent; the top only slices buses.
  for (genvar i = 0; i < int'(Width); i++) begin : g_line
    gpio_edge_channel #(
      .SyncStages (SyncStages),
      .CountWidth (CountWidth)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .gpio_in    (gpio_in[i]),
      .ack        (ack[i]),
      .edge_mode  (edge_mode_e'(edge_mode[2*i +: 2])),
      .count_clr  (count_clr),
      .irq        (irq[i]),
      .overrun    (overrun[i]),
      .gpio_sync  (gpio_sync[i]),
      .edge_count (edge_count[i*CountWidth +: CountWidth])
    );
  end

endmodule : gpio_edge_responder

// File: tb/tb_gpio_edge_responder.sv
// Scoreboard bench for gpio_edge_responder (Width=2, SyncStages=2, CountWidth=8).
// Stimulus pushes hand-computed expectations tagged with the clock cycle at
// which they must hold; a monitor pops and compares on each falling edge.
module tb_gpio_edge_responder;

  logic        clk;
  logic        rst;
  logic [1:0]  gpio_in;
  logic [1:0]  ack;
  logic [3:0]  edge_mode;
  logic        count_clr;
  logic [1:0]  irq;
  logic [1:0]  overrun;
  logic [1:0]  gpio_sync;
  logic [15:0] edge_count;

  typedef struct {
    int          cyc;
    string       name;
    logic [1:0]  irq;
    logic [1:0]  ovr;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  gpio_edge_responder #(
    .Width      (2),
    .SyncStages (2),
    .CountWidth (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_in    (gpio_in),
    .ack        (ack),
    .edge_mode  (edge_mode),
    .count_clr  (count_clr),
    .irq        (irq),
    .overrun    (overrun),
    .gpio_sync  (gpio_sync),
    .edge_count (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect state {irq, overrun, count1, count0} after posedge (now + dly).
  task automatic expect_at(input int dly, input string name, input logic [1:0] ei,
                           input logic [1:0] eo, input logic [7:0] c1, input logic [7:0] c0);
    exp_t e;
    e.cyc  = cyc + dly;
    e.name = name;
    e.irq  = ei;
    e.ovr  = eo;
    e.cnt  = {c1, c0};
    exp_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if (irq !== e.irq || overrun !== e.ovr || edge_count !== e.cnt) begin
      errors++;
      $display("FAIL %s @cyc %0d: got irq=%b ovr=%b cnt=%h, required irq=%b ovr=%b cnt=%h",
               e.name, cyc, irq, overrun, edge_count, e.irq, e.ovr, e.cnt);
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else begin
        compare(e);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    gpio_in   = 2'b01;
    ack       = 2'b00;
    edge_mode = 4'b0101;
    count_clr = 1'b0;

    // 1: line 0 held high through reset -> one rising edge after release
    tick(2);
    expect_at(1, "t1_reset", 2'b00, 2'b00, 8'd0, 8'd0);
    tick(2);
    rst = 1'b0;
    expect_at(1, "t1_rel_p1", 2'b00, 2'b00, 8'd0, 8'd0);
    expect_at(2, "t1_rel_p2", 2'b00, 2'b00, 8'd0, 8'd0);
    expect_at(3, "t1_irq", 2'b01, 2'b00, 8'd0, 8'd1);
    tick(5);

    // 2: BOTH mode pulse, no ack -> irq on rise, overrun on fall
    rst     = 1'b1;
    gpio_in = 2'b00;
    tick(2);
    expect_at(1, "t2_reset", 2'b00, 2'b00, 8'd0, 8'd0);
    tick(1);
    rst = 1'b0;
    tick(3);
    edge_mode = 4'b0111;
    gpio_in   = 2'b01;
    expect_at(2, "t2_pre_rise", 2'b00, 2'b00, 8'd0, 8'd0);
    expect_at(3, "t2_rise", 2'b01, 2'b00, 8'd0, 8'd1);
    tick(5);
    gpio_in = 2'b00;
    expect_at(2, "t2_pre_fall", 2'b01, 2'b00, 8'd0, 8'd1);
    expect_at(3, "t2_fall_ovr", 2'b01, 2'b01, 8'd0, 8'd2);
    tick(4);

    // 3: ack clears after 3 posedges; held ack clears once; new edge re-arms
    ack = 2'b01;
    expect_at(2, "t3_ack_pending", 2'b01, 2'b01, 8'd0, 8'd2);
    expect_at(3, "t3_ack_clear", 2'b00, 2'b00, 8'd0, 8'd2);
    tick(15);
    expect_at(1, "t3_ack_held", 2'b00, 2'b00, 8'd0, 8'd2);
    tick(5);
    gpio_in = 2'b01;
    expect_at(3, "t3_reassert", 2'b01, 2'b00, 8'd0, 8'd3);
    tick(4);
    ack = 2'b00;
    tick(4);

    // 4: synced gpio edge coincides with synced ack rise
    gpio_in = 2'b00;
    expect_at(3, "t4_setup_fall", 2'b01, 2'b01, 8'd0, 8'd4);
    tick(4);
    gpio_in = 2'b01;
    ack     = 2'b01;
    expect_at(3, "t4_edge_vs_ack", 2'b01, 2'b00, 8'd0, 8'd5);
    tick(4);
    ack = 2'b00;
    tick(4);

    // 5: 300 toggles on line 1 saturate its counter at 255
    edge_mode = 4'b1111;
    for (int k = 1; k <= 300; k++) begin
      gpio_in[1] = ~gpio_in[1];
      if (k == 100) expect_at(3, "t5_count_100", 2'b11, 2'b10, 8'd100, 8'd5);
      if (k == 255) expect_at(3, "t5_count_255", 2'b11, 2'b10, 8'd255, 8'd5);
      tick(1);
    end
    expect_at(3, "t5_saturated", 2'b11, 2'b10, 8'd255, 8'd5);
    tick(4);
    // count_clr in the same cycle as a detected edge -> 0
    gpio_in[1] = 1'b1;
    expect_at(3, "t5_clr_vs_edge", 2'b11, 2'b10, 8'd0, 8'd0);
    expect_at(4, "t5_clr_after", 2'b11, 2'b10, 8'd0, 8'd0);
    tick(2);
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    tick(3);

    // 6: OFF ignores edges; FALL mode; async reset mid-pulse
    ack = 2'b11;
    expect_at(3, "t6_ack_all", 2'b00, 2'b00, 8'd0, 8'd0);
    tick(4);
    ack = 2'b00;
    tick(2);
    edge_mode  = 4'b1100;
    gpio_in[0] = 1'b0;
    tick(2);
    gpio_in[0] = 1'b1;
    tick(2);
    gpio_in[0] = 1'b0;
    expect_at(3, "t6_off", 2'b00, 2'b00, 8'd0, 8'd0);
    expect_at(5, "t6_off_late", 2'b00, 2'b00, 8'd0, 8'd0);
    tick(6);
    edge_mode  = 4'b1110;
    gpio_in[0] = 1'b1;
    expect_at(3, "t6_fall_ignores_rise", 2'b00, 2'b00, 8'd0, 8'd0);
    tick(4);
    gpio_in[0] = 1'b0;
    expect_at(3, "t6_fall", 2'b01, 2'b00, 8'd0, 8'd1);
    tick(4);
    gpio_in[0] = 1'b1;
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (irq !== 2'b00 || overrun !== 2'b00 || edge_count !== 16'h0000 || gpio_sync !== 2'b00) begin
      errors++;
      $display("FAIL t6_async_reset: got irq=%b ovr=%b cnt=%h sync=%b, required all zero",
               irq, overrun, edge_count, gpio_sync);
    end
    @(negedge clk);
    rst = 1'b0;
    // line 1 (BOTH) sees a rise after release; line 0 (FALL) ignores its rise
    expect_at(2, "t6_post_rst_p2", 2'b00, 2'b00, 8'd0, 8'd0);
    expect_at(3, "t6_post_rst", 2'b10, 2'b00, 8'd1, 8'd0);
    tick(5);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 50 && exp_q.size() > 0; w++) tick(1);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gpio_edge_responder
